// File: rtl/r0_mask_scheduler.sv
// Nonzero r0 mask scheduler: filters zero RNG bytes, buffers masks in a FIFO,
// and hands one mask per AES round (0..NUM_ROUNDS) to the round controller.
module r0_mask_scheduler #(
  parameter int DEPTH        = 4,
  parameter int NUM_ROUNDS   = 10,
  parameter int MAX_ZERO_RUN = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] rnd_in,
  input  logic       rnd_valid,
  output logic       rnd_ready,
  input  logic       mask_req,
  output logic [7:0] mask_out,
  output logic       mask_valid,
  output logic [3:0] round_idx,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] zero_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int ZW = $clog2(MAX_ZERO_RUN + 1);
  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN, S_ERROR} state_t;

  state_t         state_q, state_d;
  logic [AW-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [3:0]     round_q, round_d;
  logic [7:0]     zcnt_q, zcnt_d;
  logic [ZW-1:0]  zrun_q, zrun_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic [7:0]     mem [DEPTH];

  logic accept, push, zero_in, pop, zero_fault, full, flush;

  assign full       = (cnt_q == CW'(DEPTH));
  assign busy       = (state_q == S_PRIME) || (state_q == S_RUN);
  assign rnd_ready  = busy && !full;
  assign mask_valid = (state_q == S_RUN) && (cnt_q != '0);
  // Head is shown whenever the FIFO holds data so a primed mask is visible early.
  assign mask_out   = (cnt_q != '0) ? mem[rd_q] : '0;
  assign round_idx  = round_q;
  assign done       = done_q;
  assign err        = err_q;
  assign zero_cnt   = zcnt_q;

  assign accept     = rnd_valid && rnd_ready;
  assign push       = accept && (rnd_in != '0);
  assign zero_in    = accept && (rnd_in == '0);
  assign pop        = mask_valid && mask_req;
  assign zero_fault = zero_in && (zrun_q == ZW'(MAX_ZERO_RUN - 1));

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    round_d = round_q;
    zcnt_d  = zcnt_q;
    zrun_d  = zrun_q;
    done_d  = 1'b0;
    err_d   = err_q;
    flush   = 1'b0;

    if (push) begin
      wr_d   = wr_q + 1'b1;
      zrun_d = '0;
    end
    if (zero_in) begin
      zcnt_d = (zcnt_q == 8'hFF) ? zcnt_q : zcnt_q + 8'd1;
      zrun_d = zrun_q + 1'b1;
    end
    if (pop) begin
      rd_d    = rd_q + 1'b1;
      round_d = (round_q == LAST_ROUND) ? '0 : round_q + 4'd1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    case (state_q)
      S_IDLE:  if (start) flush = 1'b1;
      S_PRIME: begin
        if (zero_fault)  state_d = S_ERROR;
        else if (full)   state_d = S_RUN;
      end
      S_RUN: begin
        // A fault on the final-pop edge wins: no done pulse.
        if (zero_fault) state_d = S_ERROR;
        else if (pop && (round_q == LAST_ROUND)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      S_ERROR: if (start) flush = 1'b1;
      default: state_d = S_IDLE;
    endcase

    if (zero_fault) err_d = 1'b1;

    if (flush) begin
      state_d = S_PRIME;
      wr_d    = '0;
      rd_d    = '0;
      cnt_d   = '0;
      round_d = '0;
      zcnt_d  = '0;
      zrun_d  = '0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      round_q <= '0;
      zcnt_q  <= '0;
      zrun_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      round_q <= round_d;
      zcnt_q  <= zcnt_d;
      zrun_q  <= zrun_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= rnd_in;
  end

endmodule

// File: tb/tb_r0_mask_scheduler.sv
// Self-checking bench for r0_mask_scheduler: directed scenarios plus a random
// phase, all compared against a queue-based behavioural model.
module tb_r0_mask_scheduler;
  localparam int DEPTH = 4;
  localparam int NR    = 10;
  localparam int MZ    = 3;

  logic       clk = 1'b0;
  logic       rst, start, rnd_valid, mask_req;
  logic [7:0] rnd_in;
  logic       rnd_ready, mask_valid, busy, done, err;
  logic [7:0] mask_out, zero_cnt;
  logic [3:0] round_idx;

  always #5 clk = ~clk;

  r0_mask_scheduler #(.DEPTH(DEPTH), .NUM_ROUNDS(NR), .MAX_ZERO_RUN(MZ)) dut (
    .clk(clk), .rst(rst), .start(start), .rnd_in(rnd_in), .rnd_valid(rnd_valid),
    .rnd_ready(rnd_ready), .mask_req(mask_req), .mask_out(mask_out),
    .mask_valid(mask_valid), .round_idx(round_idx), .busy(busy), .done(done),
    .err(err), .zero_cnt(zero_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: mode name, FIFO as a queue, plain integer counters.
  string           mode;
  byte unsigned    mq[$];
  int              m_round, m_zcnt, m_zrun;
  bit              m_done, m_err;
  bit              last_acc;
  int              pops, dones;

  function automatic bit m_busy();
    return (mode == "prime") || (mode == "run");
  endfunction
  function automatic bit m_ready();
    return m_busy() && (mq.size() < DEPTH);
  endfunction
  function automatic bit m_valid();
    return (mode == "run") && (mq.size() > 0);
  endfunction
  function automatic logic [7:0] m_out();
    return (mq.size() > 0) ? mq[0] : 8'h00;
  endfunction

  task automatic model_reset();
    mode = "idle";
    mq.delete();
    m_round = 0; m_zcnt = 0; m_zrun = 0; m_done = 0; m_err = 0;
  endtask

  task automatic model_step();
    bit acc, pp, fault;
    int n0, r0;
    byte unsigned tmp;
    acc = rnd_valid && m_ready();
    pp  = mask_req && m_valid();
    n0  = mq.size();
    r0  = m_round;
    last_acc = acc;
    m_done   = 0;
    if ((mode == "idle" || mode == "error") && start) begin
      mq.delete();
      m_round = 0; m_zcnt = 0; m_zrun = 0; m_err = 0;
      mode = "prime";
      return;
    end
    fault = 0;
    if (pp) begin
      tmp = mq.pop_front();
      m_round = (r0 == NR) ? 0 : r0 + 1;
    end
    if (acc) begin
      if (rnd_in != 8'h00) begin
        mq.push_back(rnd_in);
        m_zrun = 0;
      end else begin
        if (m_zcnt < 255) m_zcnt++;
        m_zrun++;
        fault = (m_zrun == MZ);
      end
    end
    if (fault) begin
      mode  = "error";
      m_err = 1;
    end else if (mode == "prime" && n0 == DEPTH) begin
      mode = "run";
    end else if (mode == "run" && pp && r0 == NR) begin
      mode   = "idle";
      m_done = 1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("rnd_ready",  32'(rnd_ready),  32'(m_ready()));
    check("mask_valid", 32'(mask_valid), 32'(m_valid()));
    check("mask_out",   32'(mask_out),   32'(m_out()));
    check("round_idx",  32'(round_idx),  32'(m_round));
    check("busy",       32'(busy),       32'(m_busy()));
    check("done",       32'(done),       32'(m_done));
    check("err",        32'(err),        32'(m_err));
    check("zero_cnt",   32'(zero_cnt),   32'(m_zcnt));
  endtask

  task automatic cycle();
    bit dut_pop;
    dut_pop = mask_req && (mask_valid === 1'b1);
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
    if (dut_pop) pops++;
    if (done === 1'b1) dones++;
  endtask

  function automatic logic [7:0] next_nz(input logic [7:0] b);
    return (b == 8'hFF) ? 8'h01 : b + 8'd1;
  endfunction

  logic [7:0] seq [4];
  logic [7:0] zseq [4];
  int idx;

  initial begin
    rst = 1'b1; start = 1'b0; rnd_valid = 1'b0; mask_req = 1'b0; rnd_in = 8'h00;
    model_reset();
    #1;
    check_outputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Prime with 11,22,33,44 then enter RUN.
    seq = '{8'h11, 8'h22, 8'h33, 8'h44};
    start = 1'b1; cycle(); start = 1'b0;
    rnd_valid = 1'b1; idx = 0; rnd_in = seq[0];
    for (int i = 0; i < 20 && mode != "run"; i++) begin
      cycle();
      if (last_acc) begin
        idx++;
        rnd_in = (idx < 4) ? seq[idx] : 8'h55;
      end
    end
    check("t1_valid", 32'(mask_valid), 32'd1);
    check("t1_head",  32'(mask_out),   32'h11);
    check("t1_round", 32'(round_idx),  32'd0);
    check("t1_ready", 32'(rnd_ready),  32'd0);

    // Full run with mask_req held.
    pops = 0; dones = 0; mask_req = 1'b1;
    for (int i = 0; i < 100 && dones == 0; i++) begin
      cycle();
      if (last_acc) rnd_in = next_nz(rnd_in);
    end
    check("t2_pops",  32'(pops),  32'd11);
    check("t2_dones", 32'(dones), 32'd1);
    check("t2_busy",  32'(busy),  32'd0);
    mask_req = 1'b0; rnd_valid = 1'b0;
    cycle();
    check("t2_done_pulse", 32'(done), 32'd0);

    // Zero filtering in PRIME.
    zseq = '{8'h00, 8'h05, 8'h00, 8'h07};
    start = 1'b1; cycle(); start = 1'b0;
    rnd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rnd_in = zseq[i];
      cycle();
    end
    rnd_valid = 1'b0;
    cycle();
    check("t3_zcnt", 32'(zero_cnt), 32'd2);
    check("t3_err",  32'(err),      32'd0);
    check("t3_head", 32'(mask_out), 32'h05);
    rnd_valid = 1'b1;
    rnd_in = 8'h09; cycle();
    rnd_in = 8'h0A; cycle();
    rnd_valid = 1'b0;
    cycle();
    check("t3_run", 32'(mask_valid), 32'd1);

    // start while busy is ignored.
    start = 1'b1; cycle(); start = 1'b0;
    check("t3_start_ign", 32'(zero_cnt), 32'd2);

    // Pop down to two entries, then a simultaneous push and pop.
    mask_req = 1'b1; cycle(); cycle(); mask_req = 1'b0;
    check("t4_head09", 32'(mask_out),  32'h09);
    check("t4_round2", 32'(round_idx), 32'd2);
    rnd_valid = 1'b1; rnd_in = 8'h3C; mask_req = 1'b1;
    cycle();
    rnd_valid = 1'b0; mask_req = 1'b0;
    check("t4_head0A", 32'(mask_out),  32'h0A);
    check("t4_round3", 32'(round_idx), 32'd3);
    check("t4_ready",  32'(rnd_ready), 32'd1);
    mask_req = 1'b1; cycle(); mask_req = 1'b0;
    check("t4_head3C", 32'(mask_out), 32'h3C);

    // Three consecutive zeros raise the fault.
    rnd_valid = 1'b1; rnd_in = 8'h00;
    repeat (3) cycle();
    rnd_valid = 1'b0;
    check("t5_err",   32'(err),        32'd1);
    check("t5_ready", 32'(rnd_ready),  32'd0);
    check("t5_valid", 32'(mask_valid), 32'd0);
    check("t5_zcnt",  32'(zero_cnt),   32'd5);
    start = 1'b1; cycle(); start = 1'b0;
    check("t5_err_clr",  32'(err),      32'd0);
    check("t5_zcnt_clr", 32'(zero_cnt), 32'd0);
    check("t5_prime",    32'(busy),     32'd1);
    check("t5_flushed",  32'(mask_out), 32'h00);

    // Random phase.
    for (int i = 0; i < 800; i++) begin
      start     = ($urandom_range(0, 39) == 0);
      rnd_valid = ($urandom_range(0, 3) != 0);
      rnd_in    = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      mask_req  = $urandom_range(0, 1) != 0;
      cycle();
    end

    // Asynchronous reset mid-run at round 5.
    rnd_valid = 1'b1; mask_req = 1'b1; start = 1'b1;
    for (int i = 0; i < 300 && !(mode == "run" && m_round == 5); i++) begin
      rnd_in = 8'($urandom_range(1, 255));
      cycle();
    end
    rnd_valid = 1'b0; mask_req = 1'b0; start = 1'b0;
    check("t6_round5", 32'(round_idx), 32'd5);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_ready", 32'(rnd_ready),  32'd0);
    check("t6_rst_valid", 32'(mask_valid), 32'd0);
    check("t6_rst_out",   32'(mask_out),   32'h00);
    check("t6_rst_round", 32'(round_idx),  32'd0);
    check("t6_rst_busy",  32'(busy),       32'd0);
    check("t6_rst_done",  32'(done),       32'd0);
    check("t6_rst_err",   32'(err),        32'd0);
    check("t6_rst_zcnt",  32'(zero_cnt),   32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    start = 1'b1; cycle(); start = 1'b0;
    check("t6_restart_round", 32'(round_idx), 32'd0);
    check("t6_restart_empty", 32'(mask_out),  32'h00);
    check("t6_restart_ready", 32'(rnd_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
